// File: rtl/frame_scheduler_pkg.sv
// Shared display types and widths for the screen sequencer.
package frame_scheduler_pkg;

    localparam int unsigned RGB_W   = 24;
    localparam int unsigned CH_W    = 8;
    localparam int unsigned NUM_CH  = RGB_W / CH_W;
    localparam int unsigned LEVEL_W = 3;

    typedef enum logic [1:0] {
        TITLE    = 2'd0,
        FADE_IN  = 2'd1,
        PLAY     = 2'd2,
        END_HOLD = 2'd3
    } screen_t;

endpackage

// File: rtl/frame_scheduler_if.sv
// Frame timing, control pulses and pixel buses between the sequencer and its neighbours.
interface frame_scheduler_if;
    import frame_scheduler_pkg::*;

    logic             i_frame_start;
    logic             i_start_btn;
    logic             i_game_over;
    logic             i_p1_win;
    logic [RGB_W-1:0] i_title_rgb;
    logic [RGB_W-1:0] i_game_rgb;
    logic [RGB_W-1:0] i_end_rgb;
    screen_t          o_state;
    logic             o_is_p1_win;
    logic             o_game_rst;
    logic [RGB_W-1:0] o_rgb;

    modport master (
        output i_frame_start, i_start_btn, i_game_over, i_p1_win,
        output i_title_rgb, i_game_rgb, i_end_rgb,
        input  o_state, o_is_p1_win, o_game_rst, o_rgb
    );

    modport slave (
        input  i_frame_start, i_start_btn, i_game_over, i_p1_win,
        input  i_title_rgb, i_game_rgb, i_end_rgb,
        output o_state, o_is_p1_win, o_game_rst, o_rgb
    );

endinterface

// File: rtl/frame_scheduler_rgb_fader.sv
// Scales each 8-bit channel by (level+1)/8; level 7 passes the pixel unchanged.
module frame_scheduler_rgb_fader
    import frame_scheduler_pkg::*;
(
    input  logic [RGB_W-1:0]   rgb_i,
    input  logic [LEVEL_W-1:0] level_i,
    output logic [RGB_W-1:0]   rgb_o
);

    localparam int unsigned GAIN_W = LEVEL_W + 1;
    localparam int unsigned PROD_W = CH_W + LEVEL_W;

    logic [GAIN_W-1:0] gain;

    assign gain = GAIN_W'(level_i) + GAIN_W'(1);

    // One 8x4 multiply per channel, keeping product bits [10:3].
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [PROD_W-1:0] prod;
        assign prod = PROD_W'(rgb_i[CH_W*k +: CH_W]) * PROD_W'(gain);
        assign rgb_o[CH_W*k +: CH_W] = CH_W'(prod >> LEVEL_W);
    end

endmodule

// File: rtl/frame_scheduler.sv
// Screen sequencer: selects title / faded game / game / end pixels, switching only on frame boundaries.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int unsigned FADE_STEP_FRAMES = 4,
    parameter int unsigned HOLD_FRAMES      = 180
) (
    input  logic              i_clk,
    input  logic              i_rst,
    frame_scheduler_if.slave  bus
);

    localparam int unsigned STEP_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_FRAMES);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    screen_t            state_q,     state_d;
    logic [LEVEL_W-1:0] level_q,     level_d;
    logic [STEP_W-1:0]  step_q,      step_d;
    logic [HOLD_W-1:0]  hold_q,      hold_d;
    logic               start_req_q, start_req_d;
    logic               over_req_q,  over_req_d;
    logic               pend_win_q,  pend_win_d;
    logic               win_q,       win_d;
    logic               game_rst_q,  game_rst_d;
    logic [RGB_W-1:0]   rgb_q,       rgb_d;
    logic [RGB_W-1:0]   faded_rgb;

    // Control state, counters and request latches.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= TITLE;
            level_q     <= '0;
            step_q      <= '0;
            hold_q      <= '0;
            start_req_q <= 1'b0;
            over_req_q  <= 1'b0;
            pend_win_q  <= 1'b0;
            win_q       <= 1'b0;
            game_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            step_q      <= step_d;
            hold_q      <= hold_d;
            start_req_q <= start_req_d;
            over_req_q  <= over_req_d;
            pend_win_q  <= pend_win_d;
            win_q       <= win_d;
            game_rst_q  <= game_rst_d;
        end
    end

    // Next-state logic; requests are OR'd with the live pulse so set-and-consume works on a boundary.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        step_d      = step_q;
        hold_d      = hold_q;
        start_req_d = start_req_q | bus.i_start_btn;
        over_req_d  = over_req_q | bus.i_game_over;
        pend_win_d  = bus.i_game_over ? bus.i_p1_win : pend_win_q;
        win_d       = win_q;
        game_rst_d  = 1'b0;

        unique case (state_q)
            TITLE: begin
                over_req_d = 1'b0;
                if (bus.i_frame_start && start_req_d) begin
                    state_d     = FADE_IN;
                    game_rst_d  = 1'b1;
                    level_d     = '0;
                    step_d      = '0;
                    start_req_d = 1'b0;
                end
            end
            FADE_IN: begin
                start_req_d = 1'b0;
                over_req_d  = 1'b0;
                if (bus.i_frame_start) begin
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (level_q == LEVEL_MAX) begin
                            state_d = PLAY;
                        end else begin
                            level_d = level_q + LEVEL_W'(1);
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            PLAY: begin
                start_req_d = 1'b0;
                if (bus.i_frame_start && over_req_d) begin
                    state_d    = END_HOLD;
                    win_d      = pend_win_d;
                    hold_d     = '0;
                    over_req_d = 1'b0;
                end
            end
            END_HOLD: begin
                if (bus.i_frame_start) begin
                    if (hold_q == HOLD_MAX) begin
                        if (start_req_d) begin
                            state_d     = TITLE;
                            start_req_d = 1'b0;
                        end
                    end else begin
                        hold_d      = hold_q + HOLD_W'(1);
                        start_req_d = 1'b0;
                    end
                end
            end
            default: state_d = TITLE;
        endcase
    end

    frame_scheduler_rgb_fader u_fader (
        .rgb_i   (bus.i_game_rgb),
        .level_i (level_q),
        .rgb_o   (faded_rgb)
    );

    // Pixel source select from the registered screen state.
    always_comb begin
        rgb_d = '0;
        unique case (state_q)
            TITLE:    rgb_d = bus.i_title_rgb;
            FADE_IN:  rgb_d = faded_rgb;
            PLAY:     rgb_d = bus.i_game_rgb;
            END_HOLD: rgb_d = bus.i_end_rgb;
            default:  rgb_d = '0;
        endcase
    end

    // Output pixel register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus.o_state     = state_q;
    assign bus.o_is_p1_win = win_q;
    assign bus.o_game_rst  = game_rst_q;
    assign bus.o_rgb       = rgb_q;

endmodule
